// File: rtl/uv_pred_mode_ctrl.sv
// Chroma (U|V) intra prediction mode search: walks the enabled VP8 UV modes DC/V/H/TM,
// accumulates each mode's SAD row by row and keeps the cheapest mode.
module uv_pred_mode_ctrl #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int UV_SIZE    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  top_avail,
  input  logic                                  left_avail,
  input  logic [BIT_WIDTH*BLOCK_SIZE*UV_SIZE-1:0] src,
  input  logic [BIT_WIDTH*BLOCK_SIZE*UV_SIZE-1:0] pred,
  output logic [1:0]                            mode_sel,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            best_mode,
  output logic [BIT_WIDTH+6:0]                  best_sad
);

  localparam int SAD_W  = BIT_WIDTH + 7;
  localparam int RSAD_W = BIT_WIDTH + $clog2(UV_SIZE);
  localparam int ROW_W  = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row;
  logic [SAD_W-1:0]    acc;
  logic [3:0]          mode_en;
  logic [RSAD_W-1:0]   row_sad;
  logic                has_next;
  logic [1:0]          next_mode;

  function automatic logic [BIT_WIDTH-1:0] abs_diff(input logic [BIT_WIDTH-1:0] a,
                                                    input logic [BIT_WIDTH-1:0] b);
    logic signed [BIT_WIDTH:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? BIT_WIDTH'(-d) : BIT_WIDTH'(d);
  endfunction

  always_comb begin
    row_sad = '0;
    for (int c = 0; c < UV_SIZE; c++) begin
      row_sad = row_sad + RSAD_W'(abs_diff(
        src [(int'(row) * UV_SIZE + c) * BIT_WIDTH +: BIT_WIDTH],
        pred[(int'(row) * UV_SIZE + c) * BIT_WIDTH +: BIT_WIDTH]));
    end
  end

  // Lowest-numbered enabled mode above the current one; descending scan leaves the nearest.
  always_comb begin
    has_next  = 1'b0;
    next_mode = mode_sel;
    for (int m = 3; m >= 0; m--) begin
      if (m > int'(mode_sel) && mode_en[m]) begin
        has_next  = 1'b1;
        next_mode = 2'(m);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (row == ROW_W'(BLOCK_SIZE - 1)) state_nxt = CMP;
      end
      CMP: begin
        busy      = 1'b1;
        state_nxt = has_next ? RUN : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_en   <= 4'b0001;
      mode_sel  <= 2'd0;
      row       <= '0;
      acc       <= '0;
      best_mode <= 2'd0;
      best_sad  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_en  <= {top_avail & left_avail, left_avail, top_avail, 1'b1};
          mode_sel <= 2'd0;
          row      <= '0;
          acc      <= '0;
          best_sad <= '1;
        end
        RUN: begin
          acc <= acc + SAD_W'(row_sad);
          row <= row + 1'b1;
        end
        CMP: begin
          // Strict compare: on a tie the earlier mode in evaluation order is kept.
          if (acc < best_sad) begin
            best_sad  <= acc;
            best_mode <= mode_sel;
          end
          if (has_next) begin
            mode_sel <= next_mode;
            row      <= '0;
            acc      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
